gate_vector_checker: RTL and testbench

//  Self-checking stimulus stage for the combinational gate blocks (and_gate, and_gate1, ...).

---
 rtl/gate_vector_checker_if.sv | 36 +++
 rtl/gate_vector_checker.sv | 140 ++++++++++++++
 tb/tb_gate_vector_checker.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_vector_checker_if.sv
// Bus between the vector checker and the gate under check with its controller.
// master: the checker side. slave: the environment side (controller and gate).
interface gate_vector_checker_if #(
    parameter int unsigned N_IN = 3
);
    logic            start;
    logic            dut_out;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;

    modport master (
        input  start,
        input  dut_out,
        output vec_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail
    );

    modport slave (
        output start,
        output dut_out,
        input  vec_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Sweeps all input vectors of an N_IN-input gate. Each vector is held for HOLD
// cycles, and the gate output is compared with the expected reduction function
// on the last cycle of each hold window.
module gate_vector_checker #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned HOLD = 5,
    parameter int unsigned FUNC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_vector_checker_if.master bus
);

    localparam int unsigned ERR_W  = N_IN + 1;
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [N_IN-1:0]   r_vec;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err;
    logic [N_IN-1:0]   r_first;

    state_t            w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [N_IN-1:0]   w_vec_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [N_IN-1:0]   w_first_nxt;

    logic              w_exp_c;
    logic              w_sample;
    logic              w_mismatch;
    logic [ERR_W-1:0]  w_err_upd;

    // Expected gate output for the vector currently presented.
    always_comb begin
        case (FUNC)
            32'd0:   w_exp_c = &r_vec;
            32'd1:   w_exp_c = |r_vec;
            32'd2:   w_exp_c = ^r_vec;
            default: w_exp_c = ~(&r_vec);
        endcase
    end

    assign w_sample   = (r_hold_cnt == HOLD_W'(HOLD - 1));
    assign w_mismatch = (bus.dut_out != w_exp_c);
    assign w_err_upd  = r_err + ERR_W'(w_mismatch);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_first    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_vec      <= w_vec_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err      <= w_err_nxt;
            r_first    <= w_first_nxt;
        end
    end

    // Next-state and next-output logic; start is ignored while a sweep runs.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_vec_nxt   = r_vec;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        w_first_nxt = r_first;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_hold_nxt  = '0;
                    w_vec_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_err_nxt   = '0;
                    w_first_nxt = '0;
                end
            end
            S_RUN: begin
                if (w_sample) begin
                    w_err_nxt  = w_err_upd;
                    w_hold_nxt = '0;
                    if (w_mismatch && (r_err == '0)) begin
                        w_first_nxt = r_vec;
                    end
                    if (&r_vec) begin
                        // Last vector: the final compare feeds straight into pass.
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_upd == '0);
                    end else begin
                        w_vec_nxt = r_vec + N_IN'(1);
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.vec_out    = r_vec;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.first_fail = r_first;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (2-input AND hold 5,
// 3-input AND hold 5, 2-input XOR hold 1) each driven by a modelled gate.
module tb_gate_vector_checker;

    logic       clk;
    logic       rst_n;
    logic [2:0] start;
    int         mode [3];
    int         ph_a;

    int total;
    int bad;

    gate_vector_checker_if #(.N_IN(2)) bus_a ();
    gate_vector_checker_if #(.N_IN(3)) bus_b ();
    gate_vector_checker_if #(.N_IN(2)) bus_c ();

    gate_vector_checker #(.N_IN(2), .HOLD(5), .FUNC(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    gate_vector_checker #(.N_IN(3), .HOLD(5), .FUNC(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    gate_vector_checker #(.N_IN(2), .HOLD(1), .FUNC(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model: 0 correct, 1 stuck-0, 2 stuck-1, 3 inverted,
    // 4 wrong only on vector 2, 5 wrong everywhere except the sample cycle.
    function automatic logic gate_fn(input int m, input int func, input logic [7:0] v,
                                     input int n, input bit smp);
        logic a;
        logic o;
        logic x;
        logic r;
        a = 1'b1;
        o = 1'b0;
        x = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a & v[i];
            o = o | v[i];
            x = x ^ v[i];
        end
        case (func)
            0:       r = a;
            1:       r = o;
            2:       r = x;
            default: r = ~a;
        endcase
        case (m)
            0:       return r;
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~r;
            4:       return r | (v == 8'd2);
            default: return smp ? r : ~r;
        endcase
    endfunction

    // Bench-side hold phase for instance a, restarted when a sweep is launched.
    always @(posedge clk) begin
        if (start[0] && !bus_a.busy) ph_a <= 0;
        else if (ph_a == 4)          ph_a <= 0;
        else                         ph_a <= ph_a + 1;
    end

    assign bus_a.start   = start[0];
    assign bus_b.start   = start[1];
    assign bus_c.start   = start[2];
    assign bus_a.dut_out = gate_fn(mode[0], 0, 8'(bus_a.vec_out), 2, ph_a == 4);
    assign bus_b.dut_out = gate_fn(mode[1], 0, 8'(bus_b.vec_out), 3, 1'b1);
    assign bus_c.dut_out = gate_fn(mode[2], 2, 8'(bus_c.vec_out), 2, 1'b1);

    int         sel;
    logic [7:0] cur_vec;
    logic [8:0] cur_err;
    logic [7:0] cur_ff;
    logic       cur_busy;
    logic       cur_done;
    logic       cur_pass;

    always_comb begin
        cur_vec  = 8'(bus_a.vec_out);
        cur_err  = 9'(bus_a.err_count);
        cur_ff   = 8'(bus_a.first_fail);
        cur_busy = bus_a.busy;
        cur_done = bus_a.done;
        cur_pass = bus_a.pass;
        if (sel == 1) begin
            cur_vec  = 8'(bus_b.vec_out);
            cur_err  = 9'(bus_b.err_count);
            cur_ff   = 8'(bus_b.first_fail);
            cur_busy = bus_b.busy;
            cur_done = bus_b.done;
            cur_pass = bus_b.pass;
        end else if (sel == 2) begin
            cur_vec  = 8'(bus_c.vec_out);
            cur_err  = 9'(bus_c.err_count);
            cur_ff   = 8'(bus_c.first_fail);
            cur_busy = bus_c.busy;
            cur_done = bus_c.done;
            cur_pass = bus_c.pass;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int sel;
        int m;
        int hold;
        int nvec;
        int err;
        int ff;
        int pass;
        int pulses;
    } vec_t;

    vec_t tbl [12];

    // One full sweep on instance s, checking the vector walk, latency and results.
    task automatic run_sweep(input vec_t t);
        int  n;
        int  busy_n;
        bit  seq_ok;
        int  span;
        sel  = t.sel;
        span = t.hold * t.nvec;
        @(negedge clk);
        mode[t.sel]  = t.m;
        start[t.sel] = 1'b1;
        @(negedge clk);
        start[t.sel] = 1'b0;
        n      = 1;
        busy_n = 0;
        seq_ok = 1'b1;
        while (!cur_done && n <= span + 10) begin
            if (cur_busy) busy_n++;
            if (cur_vec != 8'((n - 1) / t.hold)) seq_ok = 1'b0;
            start[t.sel] = (t.pulses != 0 && (n == 3 || n == 12)) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start[t.sel] = 1'b0;
        check($sformatf("latency[s%0d m%0d]", t.sel, t.m), n - 1, span);
        check($sformatf("busy_cycles[s%0d m%0d]", t.sel, t.m), busy_n, span);
        check($sformatf("vec_walk[s%0d m%0d]", t.sel, t.m), int'(seq_ok), 1);
        check($sformatf("err_count[s%0d m%0d]", t.sel, t.m), int'(cur_err), t.err);
        check($sformatf("first_fail[s%0d m%0d]", t.sel, t.m), int'(cur_ff), t.ff);
        check($sformatf("pass[s%0d m%0d]", t.sel, t.m), int'(cur_pass), t.pass);
        check($sformatf("busy_at_done[s%0d m%0d]", t.sel, t.m), int'(cur_busy), 0);
        @(negedge clk);
        check($sformatf("done_hold[s%0d m%0d]", t.sel, t.m), int'(cur_done), 1);
        check($sformatf("vec_final[s%0d m%0d]", t.sel, t.m), int'(cur_vec), t.nvec - 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, int'({bus_a.vec_out, bus_a.busy, bus_a.done, bus_a.pass,
                                  bus_a.err_count, bus_a.first_fail}), 0);
        check({tag, "_b"}, int'({bus_b.vec_out, bus_b.busy, bus_b.done, bus_b.pass,
                                  bus_b.err_count, bus_b.first_fail}), 0);
        check({tag, "_c"}, int'({bus_c.vec_out, bus_c.busy, bus_c.done, bus_c.pass,
                                  bus_c.err_count, bus_c.first_fail}), 0);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        sel   = 0;
        start = 3'b000;
        for (int i = 0; i < 3; i++) mode[i] = 0;
        rst_n = 1'b0;

        //        sel m  hold nvec err ff pass pulses
        tbl[0]  = '{0, 0, 5, 4, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 5, 4, 1, 3, 0, 0};
        tbl[2]  = '{0, 2, 5, 4, 3, 0, 0, 0};
        tbl[3]  = '{0, 3, 5, 4, 4, 0, 0, 0};
        tbl[4]  = '{0, 4, 5, 4, 1, 2, 0, 0};
        tbl[5]  = '{0, 5, 5, 4, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 5, 4, 0, 0, 1, 1};
        tbl[7]  = '{1, 0, 5, 8, 0, 0, 1, 0};
        tbl[8]  = '{1, 1, 5, 8, 1, 7, 0, 0};
        tbl[9]  = '{2, 0, 1, 4, 0, 0, 1, 0};
        tbl[10] = '{2, 1, 1, 4, 2, 1, 0, 0};
        tbl[11] = '{2, 2, 1, 4, 2, 0, 0, 0};

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle_state");

        for (int i = 0; i < 12; i++) run_sweep(tbl[i]);

        // Restart from DONE on the 3-input instance clears results next cycle.
        sel = 1;
        mode[1] = 0;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("restart_done", int'(cur_done), 0);
        check("restart_busy", int'(cur_busy), 1);
        check("restart_vec", int'(cur_vec), 0);
        check("restart_err", int'(cur_err), 0);
        n = 0;
        while (!cur_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("restart_pass", int'(cur_pass), 1);

        // Start held high: DONE lasts one cycle, then a fresh sweep begins.
        sel = 0;
        mode[0] = 0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        n = 1;
        while (!cur_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("held_latency", n - 1, 20);
        @(negedge clk);
        check("held_done_1cyc", int'(cur_done), 0);
        check("held_rerun_busy", int'(cur_busy), 1);
        check("held_rerun_vec", int'(cur_vec), 0);
        start[0] = 1'b0;
        n = 0;
        while (!cur_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("held_second_pass", int'(cur_pass), 1);

        // Asynchronous reset in the middle of a sweep, with vec_out at 2.
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (cur_vec != 8'd2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("mid_sweep_vec", int'(cur_vec), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_busy", int'(cur_busy), 0);
        check("post_reset_done", int'(cur_done), 0);
        check("post_reset_vec", int'(cur_vec), 0);
        run_sweep(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
